dual_update_pipelined: RTL and testbench

- Next-generation ADMM dual-variable update engine for the MPC solver.
- Performs the y-update (y += u - z over inputs, steps 0..N-2) and then the g-update (g += x - v over states, steps 0..N-1).
- Streams one element per cycle through a pipeline sized for a configurable memory read latency, using signed saturating fixed-point arithmetic.
- Reports max-abs primal residuals, a tolerance-based converged flag and a sticky saturation flag; supports abort.

---
 rtl/dual_update_pipelined.sv | 369 ++++++++++++++++++++++++++++++++++++
 tb/tb_dual_update_pipelined.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_update_pipelined.sv
// ---------------------------------------------------------------------------
// dual_update_pipelined
//
// ADMM dual-variable update engine for the MPC solver. One run performs
//   y-update : y[i] += sat(u[i] - z[i])   for i in 0 .. (N-1)*INPUT_DIM-1
//   g-update : g[i] += sat(x[i] - v[i])   for i in 0 .. N*STATE_DIM-1
// streaming one element per cycle through a pipeline sized for RD_LATENCY.
// All arithmetic is signed saturating fixed point at DATA_WIDTH bits.
// A run also produces the max-abs primal residuals, a converged flag and
// a sticky saturation flag, all latched when the run completes.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             run control
//   active_horizon           horizon N for the run (clamped to HORIZON)
//   tol_u, tol_x             unsigned residual tolerances
//   uzy_rdaddress            shared read address of the u/z/y memories
//   u/z/y_data_out           read data, valid RD_LATENCY cycles after address
//   y_wraddress/y_data_in/y_wren   y write port
//   xvg_rdaddress            shared read address of the x/v/g memories
//   x/v/g_data_out           read data, valid RD_LATENCY cycles after address
//   g_wraddress/g_data_in/g_wren   g write port
//   pri_res_u, pri_res_x     max |u-z| and max |x-v| of the last completed run
//   converged, sat_flag      status of the last completed run
//   busy, done               run status
//
// Handshake: start is a level sampled only in IDLE (abort in the same cycle
// suppresses it). busy is high from the first cycle of the run until the
// result is latched; done then stays high until start is seen low, which
// returns the block to IDLE. abort in any busy state drops the run on the
// next edge without touching the reported results.
// ---------------------------------------------------------------------------
module dual_update_pipelined #(
    parameter int STATE_DIM  = 6,
    parameter int INPUT_DIM  = 3,
    parameter int HORIZON    = 30,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           active_horizon,
    input  logic [DATA_WIDTH-1:0] tol_u,
    input  logic [DATA_WIDTH-1:0] tol_x,
    output logic [ADDR_WIDTH-1:0] uzy_rdaddress,
    input  logic [DATA_WIDTH-1:0] u_data_out,
    input  logic [DATA_WIDTH-1:0] z_data_out,
    input  logic [DATA_WIDTH-1:0] y_data_out,
    output logic [ADDR_WIDTH-1:0] y_wraddress,
    output logic [DATA_WIDTH-1:0] y_data_in,
    output logic                  y_wren,
    output logic [ADDR_WIDTH-1:0] xvg_rdaddress,
    input  logic [DATA_WIDTH-1:0] x_data_out,
    input  logic [DATA_WIDTH-1:0] v_data_out,
    input  logic [DATA_WIDTH-1:0] g_data_out,
    output logic [ADDR_WIDTH-1:0] g_wraddress,
    output logic [DATA_WIDTH-1:0] g_data_in,
    output logic                  g_wren,
    output logic [DATA_WIDTH-1:0] pri_res_u,
    output logic [DATA_WIDTH-1:0] pri_res_x,
    output logic                  converged,
    output logic                  sat_flag,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
    // DRAIN lasts RD_LATENCY+1 cycles: the last read returns, then its writeback.
    localparam logic [31:0] DRAIN_LAST = 32'(RD_LATENCY);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN_Y   = 3'd1,
        DRAIN_Y = 3'd2,
        RUN_G   = 3'd3,
        DRAIN_G = 3'd4,
        REPORT  = 3'd5,
        DONE    = 3'd6
    } state_t;

    // state is the observable FSM state for checkers.
    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic        load_run;
    logic        kill;

    logic [31:0] n_eff;
    logic [31:0] len_y_calc;
    logic [31:0] len_x_calc;
    logic [31:0] len_y_q;
    logic [31:0] len_x_q;

    // Read pipeline: one slot per cycle of memory latency.
    logic [RD_LATENCY-1:0] v_pipe;
    logic [RD_LATENCY-1:0] s_pipe;
    logic [AW-1:0]         a_pipe [RD_LATENCY];

    logic          issue_valid;
    logic          issue_seg;
    logic [AW-1:0] issue_addr;
    logic          cap_valid;
    logic          cap_seg;
    logic [AW-1:0] cap_addr;

    // Arithmetic on the element being captured this cycle.
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] op_old;
    logic [DW:0]   diff_wide;
    logic [DW:0]   sum_wide;
    logic [DW-1:0] diff_sat;
    logic [DW-1:0] new_val;
    logic [DW-1:0] diff_abs;
    logic          diff_ovf;
    logic          sum_ovf;
    logic          abs_ovf;
    logic          sat_event;

    logic [DW-1:0] max_u;
    logic [DW-1:0] max_x;
    logic          sat_sticky;

    function automatic logic [DW-1:0] sat_narrow(input logic [DW:0] v);
        if (v[DW] != v[DW-1]) begin
            return v[DW] ? SAT_MIN : SAT_MAX;
        end
        return v[DW-1:0];
    endfunction

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
    assign kill = abort && busy;

    // Segment lengths for a run requested this cycle.
    always_comb begin
        n_eff      = (active_horizon > 32'(HORIZON)) ? 32'(HORIZON) : active_horizon;
        len_y_calc = (n_eff == 32'd0) ? 32'd0 : (n_eff - 32'd1) * 32'(INPUT_DIM);
        len_x_calc = n_eff * 32'(STATE_DIM);
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 32'd0;
            len_y_q <= 32'd0;
            len_x_q <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load_run) begin
                len_y_q <= len_y_calc;
                len_x_q <= len_x_calc;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_run   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load_run = 1'b1;
                    cnt_next = 32'd0;
                    // Empty segments are skipped outright.
                    if (len_y_calc != 32'd0) begin
                        state_next = RUN_Y;
                    end else if (len_x_calc != 32'd0) begin
                        state_next = RUN_G;
                    end else begin
                        state_next = REPORT;
                    end
                end
            end
            RUN_Y: begin
                if (cnt == len_y_q - 32'd1) begin
                    state_next = DRAIN_Y;
                    cnt_next   = 32'd0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            DRAIN_Y: begin
                if (cnt == DRAIN_LAST) begin
                    cnt_next   = 32'd0;
                    state_next = (len_x_q != 32'd0) ? RUN_G : REPORT;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            RUN_G: begin
                if (cnt == len_x_q - 32'd1) begin
                    state_next = DRAIN_G;
                    cnt_next   = 32'd0;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            DRAIN_G: begin
                if (cnt == DRAIN_LAST) begin
                    cnt_next   = 32'd0;
                    state_next = REPORT;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            REPORT: begin
                state_next = DONE;
            end
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 32'd0;
            end
        endcase
        if (kill) begin
            state_next = IDLE;
            cnt_next   = 32'd0;
        end
    end

    // -----------------------------------------------------------------------
    // Read addresses: registered so that the address of element i is on the
    // bus during the i-th RUN cycle of its segment.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uzy_rdaddress <= '0;
            xvg_rdaddress <= '0;
        end else begin
            if (state_next == RUN_Y) begin
                uzy_rdaddress <= cnt_next[AW-1:0];
            end
            if (state_next == RUN_G) begin
                xvg_rdaddress <= cnt_next[AW-1:0];
            end
        end
    end

    always_comb begin
        issue_valid = (state == RUN_Y) || (state == RUN_G);
        issue_seg   = (state == RUN_G);
        issue_addr  = issue_seg ? xvg_rdaddress : uzy_rdaddress;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pipe <= '0;
            s_pipe <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                a_pipe[k] <= '0;
            end
        end else begin
            // abort discards every read still in flight.
            v_pipe[0] <= issue_valid && !kill;
            s_pipe[0] <= issue_seg;
            a_pipe[0] <= issue_addr;
            for (int k = 1; k < RD_LATENCY; k++) begin
                v_pipe[k] <= v_pipe[k-1] && !kill;
                s_pipe[k] <= s_pipe[k-1];
                a_pipe[k] <= a_pipe[k-1];
            end
        end
    end

    assign cap_valid = v_pipe[RD_LATENCY-1];
    assign cap_seg   = s_pipe[RD_LATENCY-1];
    assign cap_addr  = a_pipe[RD_LATENCY-1];

    // -----------------------------------------------------------------------
    // Saturating update. The two segments never overlap in the pipeline, so
    // one datapath serves both.
    // -----------------------------------------------------------------------
    always_comb begin
        op_a      = cap_seg ? x_data_out : u_data_out;
        op_b      = cap_seg ? v_data_out : z_data_out;
        op_old    = cap_seg ? g_data_out : y_data_out;
        diff_wide = {op_a[DW-1], op_a} - {op_b[DW-1], op_b};
        diff_ovf  = diff_wide[DW] ^ diff_wide[DW-1];
        diff_sat  = sat_narrow(diff_wide);
        sum_wide  = {op_old[DW-1], op_old} + {diff_sat[DW-1], diff_sat};
        sum_ovf   = sum_wide[DW] ^ sum_wide[DW-1];
        new_val   = sat_narrow(sum_wide);
        abs_ovf   = 1'b0;
        diff_abs  = diff_sat;
        // |min| has no positive representation; clip it and flag it.
        if (diff_sat == SAT_MIN) begin
            diff_abs = SAT_MAX;
            abs_ovf  = 1'b1;
        end else if (diff_sat[DW-1]) begin
            diff_abs = -diff_sat;
        end
        sat_event = diff_ovf || sum_ovf || abs_ovf;
    end

    // Writeback and running residuals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_wren      <= 1'b0;
            g_wren      <= 1'b0;
            y_wraddress <= '0;
            g_wraddress <= '0;
            y_data_in   <= '0;
            g_data_in   <= '0;
            max_u       <= '0;
            max_x       <= '0;
            sat_sticky  <= 1'b0;
        end else begin
            y_wren <= 1'b0;
            g_wren <= 1'b0;
            if (load_run) begin
                max_u      <= '0;
                max_x      <= '0;
                sat_sticky <= 1'b0;
            end else if (cap_valid && !kill) begin
                if (cap_seg) begin
                    g_wren      <= 1'b1;
                    g_wraddress <= cap_addr;
                    g_data_in   <= new_val;
                    if (diff_abs > max_x) begin
                        max_x <= diff_abs;
                    end
                end else begin
                    y_wren      <= 1'b1;
                    y_wraddress <= cap_addr;
                    y_data_in   <= new_val;
                    if (diff_abs > max_u) begin
                        max_u <= diff_abs;
                    end
                end
                if (sat_event) begin
                    sat_sticky <= 1'b1;
                end
            end
        end
    end

    // Reported results change only when a run completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pri_res_u <= '0;
            pri_res_x <= '0;
            converged <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (state == REPORT && !kill) begin
            pri_res_u <= max_u;
            pri_res_x <= max_x;
            converged <= (max_u <= tol_u) && (max_x <= tol_x);
            sat_flag  <= sat_sticky;
        end
    end

endmodule

// File: tb/tb_dual_update_pipelined.sv
module tb_dual_update_pipelined;

  localparam int RL = 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] active_horizon;
  logic [31:0] tol_u;
  logic [31:0] tol_x;
  logic [8:0]  uzy_rdaddress;
  logic [31:0] u_data_out;
  logic [31:0] z_data_out;
  logic [31:0] y_data_out;
  logic [8:0]  y_wraddress;
  logic [31:0] y_data_in;
  logic        y_wren;
  logic [8:0]  xvg_rdaddress;
  logic [31:0] x_data_out;
  logic [31:0] v_data_out;
  logic [31:0] g_data_out;
  logic [8:0]  g_wraddress;
  logic [31:0] g_data_in;
  logic        g_wren;
  logic [31:0] pri_res_u;
  logic [31:0] pri_res_x;
  logic        converged;
  logic        sat_flag;
  logic        busy;
  logic        done;

  dual_update_pipelined #(
    .STATE_DIM(6), .INPUT_DIM(3), .HORIZON(30),
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .RD_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .active_horizon(active_horizon), .tol_u(tol_u), .tol_x(tol_x),
    .uzy_rdaddress(uzy_rdaddress),
    .u_data_out(u_data_out), .z_data_out(z_data_out), .y_data_out(y_data_out),
    .y_wraddress(y_wraddress), .y_data_in(y_data_in), .y_wren(y_wren),
    .xvg_rdaddress(xvg_rdaddress),
    .x_data_out(x_data_out), .v_data_out(v_data_out), .g_data_out(g_data_out),
    .g_wraddress(g_wraddress), .g_data_in(g_data_in), .g_wren(g_wren),
    .pri_res_u(pri_res_u), .pri_res_x(pri_res_x),
    .converged(converged), .sat_flag(sat_flag), .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model and scoreboard state ----------------
  logic [31:0] u_mem [512];
  logic [31:0] z_mem [512];
  logic [31:0] y_mem [512];
  logic [31:0] x_mem [512];
  logic [31:0] v_mem [512];
  logic [31:0] g_mem [512];
  logic [8:0]  uzy_hist [5];
  logic [8:0]  xvg_hist [5];

  logic [40:0] y_exp_q [$];
  logic [40:0] g_exp_q [$];

  int n_checks;
  int n_pass;
  int cyc;
  int y_wr_n;
  int g_wr_n;
  int done_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock: record writes of the cycle just entered, then present read
  // data with RL cycles of latency.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (y_wren) begin
      y_wr_n++;
      if (y_exp_q.size() > 0) check("y_write", 64'({y_wraddress, y_data_in}), 64'(y_exp_q.pop_front()));
      y_mem[y_wraddress] = y_data_in;
    end
    if (g_wren) begin
      g_wr_n++;
      if (g_exp_q.size() > 0) check("g_write", 64'({g_wraddress, g_data_in}), 64'(g_exp_q.pop_front()));
      g_mem[g_wraddress] = g_data_in;
    end
    for (int k = 4; k > 0; k--) begin
      uzy_hist[k] = uzy_hist[k-1];
      xvg_hist[k] = xvg_hist[k-1];
    end
    uzy_hist[0] = uzy_rdaddress;
    xvg_hist[0] = xvg_rdaddress;
    u_data_out = u_mem[uzy_hist[RL]];
    z_data_out = z_mem[uzy_hist[RL]];
    y_data_out = y_mem[uzy_hist[RL]];
    x_data_out = x_mem[xvg_hist[RL]];
    v_data_out = v_mem[xvg_hist[RL]];
    g_data_out = g_mem[xvg_hist[RL]];
  endtask

  task automatic fill(input logic [31:0] uu, input logic [31:0] zz, input logic [31:0] yy,
                      input logic [31:0] xx, input logic [31:0] vv, input logic [31:0] gg);
    for (int i = 0; i < 512; i++) begin
      u_mem[i] = uu; z_mem[i] = zz; y_mem[i] = yy;
      x_mem[i] = xx; v_mem[i] = vv; g_mem[i] = gg;
    end
  endtask

  task automatic exp_build(input int ly, input int lx, input logic [31:0] yv, input logic [31:0] gv);
    y_exp_q.delete();
    g_exp_q.delete();
    for (int i = 0; i < ly; i++) y_exp_q.push_back({9'(i), yv});
    for (int i = 0; i < lx; i++) g_exp_q.push_back({9'(i), gv});
  endtask

  // Start a run in the current cycle (cycle 0) and wait for done.
  task automatic do_run(input logic [31:0] n, input bit hold, input int budget);
    active_horizon = n;
    start = 1'b1;
    cyc = 0;
    y_wr_n = 0;
    g_wr_n = 0;
    done_cyc = -1;
    for (int i = 0; i < budget && done_cyc < 0; i++) begin
      tick();
      if (!hold) start = 1'b0;
      if (done && done_cyc < 0) done_cyc = cyc;
    end
    check("done_seen", 64'(done), 64'(1));
    if (!hold) tick();
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    y_wr_n = 0;
    g_wr_n = 0;
    done_cyc = -1;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    active_horizon = 32'd0;
    tol_u = 32'd3;
    tol_x = 32'd2;
    u_data_out = '0; z_data_out = '0; y_data_out = '0;
    x_data_out = '0; v_data_out = '0; g_data_out = '0;
    for (int k = 0; k < 5; k++) begin
      uzy_hist[k] = '0;
      xvg_hist[k] = '0;
    end
    fill(32'd5, 32'd2, 32'd10, 32'd1, 32'd4, 32'd0);

    // Reset state
    tick(); tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_y_wren", 64'(y_wren), 64'(0));
    check("rst_g_wren", 64'(g_wren), 64'(0));
    check("rst_uzy_addr", 64'(uzy_rdaddress), 64'(0));
    check("rst_xvg_addr", 64'(xvg_rdaddress), 64'(0));
    check("rst_y_data", 64'(y_data_in), 64'(0));
    check("rst_res_u", 64'(pri_res_u), 64'(0));
    check("rst_res_x", 64'(pri_res_x), 64'(0));
    check("rst_conv", 64'(converged), 64'(0));
    check("rst_sat", 64'(sat_flag), 64'(0));
    rst = 1'b0;
    tick();

    // N=4 uniform: y=13, g=-3, residuals 3/3, tol_x=2 -> not converged
    fill(32'd5, 32'd2, 32'd10, 32'd1, 32'd4, 32'd0);
    exp_build(9, 24, 32'd13, 32'hFFFF_FFFD);
    do_run(32'd4, 1'b0, 200);
    check("t1_latency", 64'(done_cyc), 64'(41));
    check("t1_y_count", 64'(y_wr_n), 64'(9));
    check("t1_g_count", 64'(g_wr_n), 64'(24));
    check("t1_res_u", 64'(pri_res_u), 64'(3));
    check("t1_res_x", 64'(pri_res_x), 64'(3));
    check("t1_conv", 64'(converged), 64'(0));
    check("t1_sat", 64'(sat_flag), 64'(0));
    check("t1_idle", 64'(busy | done), 64'(0));

    // Rerun with tol_x=3 -> converged
    tol_x = 32'd3;
    fill(32'd5, 32'd2, 32'd10, 32'd1, 32'd4, 32'd0);
    exp_build(9, 24, 32'd13, 32'hFFFF_FFFD);
    do_run(32'd4, 1'b0, 200);
    check("t2_latency", 64'(done_cyc), 64'(41));
    check("t2_conv", 64'(converged), 64'(1));
    check("t2_sat", 64'(sat_flag), 64'(0));

    // Saturation: sum overflow at y[4], diff overflow at addr 7
    fill(32'd5, 32'd2, 32'd10, 32'd1, 32'd4, 32'd0);
    y_mem[4] = 32'h7FFF_FFF0; u_mem[4] = 32'h0000_0025; z_mem[4] = 32'd5;
    u_mem[7] = 32'h8000_0000; z_mem[7] = 32'd1;
    exp_build(9, 24, 32'd13, 32'hFFFF_FFFD);
    y_exp_q[4] = {9'd4, 32'h7FFF_FFFF};
    y_exp_q[7] = {9'd7, 32'h8000_000A};
    do_run(32'd4, 1'b0, 200);
    check("t3_y4", 64'(y_mem[4]), 64'(32'h7FFF_FFFF));
    check("t3_y7", 64'(y_mem[7]), 64'(32'h8000_000A));
    check("t3_res_u", 64'(pri_res_u), 64'(32'h7FFF_FFFF));
    check("t3_res_x", 64'(pri_res_x), 64'(3));
    check("t3_sat", 64'(sat_flag), 64'(1));
    check("t3_conv", 64'(converged), 64'(0));

    // N=1: y segment skipped, 6 g writes, residuals re-cleared
    fill(32'd5, 32'd2, 32'd10, 32'd1, 32'd4, 32'd0);
    exp_build(0, 6, 32'd0, 32'hFFFF_FFFD);
    do_run(32'd1, 1'b0, 100);
    check("t4_latency", 64'(done_cyc), 64'(11));
    check("t4_y_count", 64'(y_wr_n), 64'(0));
    check("t4_g_count", 64'(g_wr_n), 64'(6));
    check("t4_res_u", 64'(pri_res_u), 64'(0));
    check("t4_res_x", 64'(pri_res_x), 64'(3));
    check("t4_sat", 64'(sat_flag), 64'(0));

    // N=0: no writes, done at cycle 2
    exp_build(0, 0, 32'd0, 32'd0);
    do_run(32'd0, 1'b0, 50);
    check("t5_latency", 64'(done_cyc), 64'(2));
    check("t5_writes", 64'(y_wr_n + g_wr_n), 64'(0));
    check("t5_res_u", 64'(pri_res_u), 64'(0));
    check("t5_res_x", 64'(pri_res_x), 64'(0));
    check("t5_conv", 64'(converged), 64'(1));

    // N=100 clamps to 30: LY=87, LX=180
    fill(32'd5, 32'd2, 32'd10, 32'd1, 32'd4, 32'd0);
    exp_build(87, 180, 32'd13, 32'hFFFF_FFFD);
    do_run(32'd100, 1'b0, 600);
    check("t6_latency", 64'(done_cyc), 64'(275));
    check("t6_y_count", 64'(y_wr_n), 64'(87));
    check("t6_g_count", 64'(g_wr_n), 64'(180));
    check("t6_conv", 64'(converged), 64'(1));

    // Abort at the 5th RUN_G cycle (cycle 17)
    fill(32'd9, 32'd2, 32'd10, 32'd20, 32'd4, 32'd0);
    exp_build(0, 0, 32'd0, 32'd0);
    active_horizon = 32'd4;
    start = 1'b1;
    cyc = 0;
    y_wr_n = 0;
    g_wr_n = 0;
    while (cyc < 17) begin
      tick();
      start = 1'b0;
    end
    check("t7_busy_pre", 64'(busy), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t7_busy_post", 64'(busy), 64'(0));
    check("t7_g_wren_post", 64'(g_wren), 64'(0));
    repeat (10) tick();
    check("t7_y_count", 64'(y_wr_n), 64'(9));
    check("t7_g_count", 64'(g_wr_n), 64'(2));
    check("t7_done", 64'(done), 64'(0));
    check("t7_res_u_kept", 64'(pri_res_u), 64'(3));
    check("t7_res_x_kept", 64'(pri_res_x), 64'(3));
    check("t7_conv_kept", 64'(converged), 64'(1));

    // A fresh run after the abort completes normally
    fill(32'd5, 32'd2, 32'd10, 32'd1, 32'd4, 32'd0);
    exp_build(9, 24, 32'd13, 32'hFFFF_FFFD);
    do_run(32'd4, 1'b0, 200);
    check("t7b_latency", 64'(done_cyc), 64'(41));
    check("t7b_g_count", 64'(g_wr_n), 64'(24));
    check("t7b_res_x", 64'(pri_res_x), 64'(3));

    // abort and start together in IDLE: nothing starts
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t8_no_start", 64'(busy), 64'(0));
    tick();
    check("t8_still_idle", 64'(busy | done), 64'(0));

    // start held high for the whole run and through DONE
    fill(32'd5, 32'd2, 32'd10, 32'd1, 32'd4, 32'd0);
    exp_build(9, 24, 32'd13, 32'hFFFF_FFFD);
    do_run(32'd4, 1'b1, 200);
    check("t9_latency", 64'(done_cyc), 64'(41));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t9_done_hold", 64'(done), 64'(1));
    end
    check("t9_busy_hold", 64'(busy), 64'(0));
    start = 1'b0;
    tick();
    check("t9_done_drop", 64'(done), 64'(0));
    check("t9_y_count", 64'(y_wr_n), 64'(9));
    check("t9_g_count", 64'(g_wr_n), 64'(24));

    // Asynchronous reset in the middle of the g segment
    fill(32'd5, 32'd2, 32'd10, 32'd1, 32'd4, 32'd0);
    exp_build(0, 0, 32'd0, 32'd0);
    active_horizon = 32'd4;
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    while (cyc < 20) tick();
    check("t10_g_wren_pre", 64'(g_wren), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("t10_busy", 64'(busy), 64'(0));
    check("t10_g_wren", 64'(g_wren), 64'(0));
    check("t10_xvg_addr", 64'(xvg_rdaddress), 64'(0));
    check("t10_res_u", 64'(pri_res_u), 64'(0));
    check("t10_res_x", 64'(pri_res_x), 64'(0));
    check("t10_conv", 64'(converged), 64'(0));
    #1 rst = 1'b0;
    tick();
    check("t10_idle", 64'(busy | done), 64'(0));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
